// File: rtl/register_pipe.sv
// Elastic register pipeline: DEPTH stages of W-bit data with per-stage valid,
// ready/valid handshake on both ends, bubble collapsing and synchronous flush.
module register_pipe #(
    parameter int W     = 16,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 D,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 Q,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] acc;
    logic             push;
    logic             pop;

    // Walk from the output side; "room" is whether the downstream neighbour
    // can take a word this cycle, which becomes acc[i] for the next stage up.
    always_comb begin
        logic        room;
        int unsigned idx;
        adv  = '0;
        acc  = '0;
        room = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx      = DEPTH - 1 - k;
            adv[idx] = valid_q[idx] && room;
            acc[idx] = !valid_q[idx] || adv[idx];
            room     = acc[idx];
        end
    end

    assign in_ready  = acc[0] && !flush;
    assign out_valid = valid_q[DEPTH-1];
    assign Q         = data_q[DEPTH-1];
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
        end else begin
            if (push) begin
                valid_d[0] = 1'b1;
                data_d[0]  = D;
            end else if (adv[0]) begin
                valid_d[0] = 1'b0;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (adv[i-1]) begin
                    valid_d[i] = 1'b1;
                    data_d[i]  = data_q[i-1];
                end else if (adv[i]) begin
                    valid_d[i] = 1'b0;
                end
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_register_pipe.sv
// Bench for register_pipe: word/position queue model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_register_pipe;

    localparam int W     = 16;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [W-1:0]  D, Q;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    register_pipe #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .D(D),
        .out_valid(out_valid), .out_ready(out_ready), .Q(Q),
        .count(count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: words in acceptance order (index 0 = oldest) with their stage index.
    logic [W-1:0] m_data[$];
    int           m_pos[$];
    int           np[$];
    logic [W-1:0] m_q;
    bit           m_pop, m_rdy;
    bit           model_ok = 1'b0;
    bit           r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A word moves one stage if the slot ahead is free after the older word's move.
    function automatic void model_plan(bit ordy, bit fl);
        int limit;
        np.delete();
        m_pop = (m_pos.size() > 0 && m_pos[0] == DEPTH-1 && ordy);
        limit = DEPTH-1;
        foreach (m_pos[k]) begin
            if (k == 0 && m_pop) begin
                np.push_back(-1);
            end else begin
                int p;
                int n;
                p = m_pos[k];
                n = (p + 1 <= limit) ? p + 1 : p;
                np.push_back(n);
                limit = n - 1;
            end
        end
        m_rdy = !fl && (np.size() == 0 || np[np.size()-1] != 0);
    endfunction

    function automatic void model_commit(bit iv, logic [W-1:0] d, bit fl, bit rs);
        if (rs || fl) begin
            m_data.delete();
            m_pos.delete();
            m_q = '0;
            return;
        end
        foreach (np[k]) m_pos[k] = np[k];
        if (m_pop) begin
            void'(m_data.pop_front());
            void'(m_pos.pop_front());
        end
        if (iv && m_rdy) begin
            m_data.push_back(d);
            m_pos.push_back(0);
        end
        if (m_pos.size() > 0 && m_pos[0] == DEPTH-1) m_q = m_data[0];
    endfunction

    task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy,
                        input bit fl, input bit rs, output bit rdy);
        @(negedge clk);
        in_valid  = iv;
        D         = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        model_plan(ordy, fl);
        rdy = in_ready;
        if (model_ok) begin
            check("in_ready",  32'(in_ready),  32'(m_rdy));
            check("out_valid", 32'(out_valid), 32'(m_pos.size() > 0 && m_pos[0] == DEPTH-1));
            check("Q",         32'(Q),         32'(m_q));
            check("count",     32'(count),     32'(m_data.size()));
        end
        @(posedge clk);
        model_commit(iv, d, fl, rs);
        if (rs) model_ok = 1'b1;
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input bit ordy, output bit rdy);
        step(1'b1, d, ordy, 1'b0, 1'b0, rdy);
    endtask

    task automatic idle(input bit ordy);
        bit x;
        step(1'b0, '0, ordy, 1'b0, 1'b0, x);
    endtask

    task automatic do_reset();
        bit x;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, x);
    endtask

    initial begin
        bit rs_b, fl_b, iv_b, or_b;
        int pct;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; D = '0;

        // Reset state
        do_reset();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst Q",         32'(Q),         32'h0);
        check("rst count",     32'(count),     32'd0);

        // Stream, out_ready=1
        push(16'h0001, 1'b1, r);
        check("stream rdy", 32'(r), 32'd1);
        push(16'h0002, 1'b1, r);
        push(16'h0003, 1'b1, r);
        check("stream Q1", 32'(Q), 32'h0001);
        check("stream ov1", 32'(out_valid), 32'd1);
        check("stream peak count", 32'(count), 32'd3);
        idle(1'b1);
        check("stream Q2", 32'(Q), 32'h0002);
        idle(1'b1);
        check("stream Q3", 32'(Q), 32'h0003);
        check("stream count tail", 32'(count), 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure
        do_reset();
        push(16'h000A, 1'b0, r);
        push(16'h000B, 1'b0, r);
        push(16'h000C, 1'b0, r);
        check("bp count full", 32'(count), 32'd3);
        push(16'h000D, 1'b0, r);
        check("bp rdy full", 32'(r), 32'd0);
        check("bp hold Q", 32'(Q), 32'h000A);
        push(16'h000D, 1'b1, r);
        check("bp rdy release", 32'(r), 32'd1);
        check("bp Q B", 32'(Q), 32'h000B);
        check("bp count", 32'(count), 32'd3);
        idle(1'b1);
        check("bp Q C", 32'(Q), 32'h000C);
        idle(1'b1);
        check("bp Q D", 32'(Q), 32'h000D);
        idle(1'b1);

        // Bubble collapse
        do_reset();
        push(16'h0011, 1'b0, r);
        idle(1'b0);
        idle(1'b0);
        push(16'h0022, 1'b0, r);
        idle(1'b0);
        check("bubble count", 32'(count), 32'd2);
        check("bubble Q", 32'(Q), 32'h0011);
        idle(1'b1);
        check("bubble no gap Q", 32'(Q), 32'h0022);
        check("bubble no gap ov", 32'(out_valid), 32'd1);
        idle(1'b1);
        check("bubble drained", 32'(out_valid), 32'd0);

        // Flush with input offered
        do_reset();
        push(16'h1234, 1'b0, r);
        push(16'h5678, 1'b0, r);
        step(1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, r);
        check("flush rdy", 32'(r), 32'd0);
        check("flush count", 32'(count), 32'd0);
        check("flush ov", 32'(out_valid), 32'd0);
        check("flush Q", 32'(Q), 32'h0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Reset mid-operation
        do_reset();
        push(16'h0A0A, 1'b0, r);
        push(16'h0B0B, 1'b0, r);
        push(16'h0C0C, 1'b0, r);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, r);
        check("mrst ov", 32'(out_valid), 32'd0);
        check("mrst Q", 32'(Q), 32'h0);
        check("mrst count", 32'(count), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, r);
        check("mrst rdy", 32'(r), 32'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Simultaneous in/out on a full pipe
        do_reset();
        push(16'h0101, 1'b0, r);
        push(16'h0202, 1'b0, r);
        push(16'h0303, 1'b0, r);
        push(16'h00FF, 1'b1, r);
        check("sim rdy", 32'(r), 32'd1);
        check("sim count", 32'(count), 32'd3);
        check("sim Q", 32'(Q), 32'h0202);
        idle(1'b1);
        idle(1'b1);
        check("sim Q FF", 32'(Q), 32'h00FF);
        idle(1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            pct  = ((i / 300) % 2 == 1) ? 30 : 85;
            rs_b = ($urandom_range(0, 99) < 2);
            fl_b = ($urandom_range(0, 99) < 4);
            iv_b = ($urandom_range(0, 99) < 75);
            or_b = ($urandom_range(0, 99) < pct);
            step(iv_b, W'($urandom), or_b, fl_b, rs_b, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
